irq_capture_4: RTL and testbench

IRQ_CAPTURE_4 -- requirements
Module: irq_capture_4

---
 rtl/irq_pkg.sv | 6 +
 rtl/irq_edge_detect.sv | 48 ++++
 rtl/irq_capture_4.sv | 51 +++++
 tb/tb_irq_capture_4.sv | 123 ++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared widths and FSM states for the 4-line interrupt capture block.
package irq_pkg;
  localparam int REQ_W = 4;
  localparam int ID_W = 2;
  typedef enum logic [1:0] {IDLE, ASSERT, SETTLE} state_t;
endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect: per-line edge/level capture with an optional 2-flop synchronizer.
// Define IRQ_CAPTURE_SYNC_EN to synchronize req before capture.
module irq_edge_detect #(
  parameter logic EDGE_MODE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic hit
);
  logic smp, warm, prev_d, prev_q, vld_d, vld_q;
`ifdef IRQ_CAPTURE_SYNC_EN
  logic [1:0] sync_d, sync_q, warm_d, warm_q;
  always_comb begin
    sync_d = {sync_q[0], req};
    warm_d = {warm_q[0], 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= sync_d;
      warm_q <= warm_d;
    end
  end
  assign smp = sync_q[1];
  assign warm = warm_q[1];
`else
  assign smp = req;
  assign warm = 1'b1;
`endif
  // vld_q gates out the bogus edge seen while history is still at its reset value
  always_comb begin
    prev_d = smp;
    vld_d = warm;
    hit = EDGE_MODE ? (vld_q & smp & ~prev_q) : smp;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: rtl/irq_capture_4.sv
// irq_capture_4: 4-line interrupt capture with mask, ack handshake and sticky overflow.
// Define IRQ_CAPTURE_SYNC_EN to add a 2-flop input synchronizer per line.
module irq_capture_4
  import irq_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  input  logic [REQ_W-1:0] mask,
  output logic [REQ_W-1:0] pend,
  output logic             irq,
  input  logic             ack,
  input  logic [ID_W-1:0]  ack_id,
  output logic [REQ_W-1:0] ovf
);
  logic [REQ_W-1:0] hit, clr, pnd_d, pnd_q, ovf_d, ovf_q;
  state_t state_d, state_q;
  for (genvar i = 0; i < REQ_W; i++) begin : g_bit
    irq_edge_detect #(.EDGE_MODE(EDGE_MODE != 0)) u_det (
      .clk(clk),
      .rst_n(rst_n),
      .req(req[i]),
      .hit(hit[i])
    );
  end
  assign pend = pnd_q & ~mask;
  assign irq = state_q == ASSERT;
  assign ovf = ovf_q;
  // a masked or already-clear ack target is consumed without touching pnd
  always_comb begin
    clr = (state_q == ASSERT && ack) ? (REQ_W'(1) << ack_id) & ~mask : '0;
    pnd_d = (pnd_q & ~clr) | hit;
    ovf_d = ovf_q | ((EDGE_MODE != 0) ? hit & pnd_q & ~clr : '0);
    state_d = state_q == IDLE   ? (|pend ? ASSERT : IDLE) :
              state_q == ASSERT ? (ack ? SETTLE : (|pend ? ASSERT : IDLE)) :
              IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pnd_q <= '0;
      ovf_q <= '0;
      state_q <= IDLE;
    end else begin
      pnd_q <= pnd_d;
      ovf_q <= ovf_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_irq_capture_4.sv
// tb_irq_capture_4: scoreboard bench for irq_capture_4 in edge mode.
module tb_irq_capture_4;
`ifdef IRQ_CAPTURE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0, irq;
  logic [3:0] req = '0, mask = '0, pend, ovf;
  logic [1:0] ack_id = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] pend;
    logic       irq;
    logic [3:0] ovf;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  irq_capture_4 #(.EDGE_MODE(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .mask(mask),
    .pend(pend),
    .irq(irq),
    .ack(ack),
    .ack_id(ack_id),
    .ovf(ovf)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] m, input logic a,
                      input logic [1:0] id, input logic [3:0] ep, input logic ei, input logic [3:0] eo);
    exp_t e;
    req = r;
    mask = m;
    ack = a;
    ack_id = id;
    sb.push_back('{ep, ei, eo});
    @(posedge clk);
    #1;
    ack = 1'b0;
    e = sb.pop_front();
    check({tag, ".pend"}, pend, e.pend);
    check({tag, ".irq"}, irq, e.irq);
    check({tag, ".ovf"}, ovf, e.ovf);
  endtask
  initial begin
    int n;
    #2;
    check("rst.pend", pend, 4'h0);
    check("rst.irq", irq, 1'b0);
    check("rst.ovf", ovf, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle", 4'b0000, 4'h0, 0, 0, 4'b0000, 0, 4'b0000);
    step("a1", 4'b0100, 4'h0, 0, 0, 4'b0100, 0, 4'b0000);
    step("a2", 4'b0100, 4'h0, 0, 0, 4'b0100, 1, 4'b0000);
    step("a3", 4'b0100, 4'h0, 1, 2, 4'b0000, 0, 4'b0000);
    step("a4", 4'b0000, 4'h0, 0, 0, 4'b0000, 0, 4'b0000);
    step("b1", 4'b1001, 4'h0, 0, 0, 4'b1001, 0, 4'b0000);
    step("b2", 4'b0000, 4'h0, 0, 0, 4'b1001, 1, 4'b0000);
    step("b3", 4'b0000, 4'h0, 1, 3, 4'b0001, 0, 4'b0000);
    step("b4", 4'b0000, 4'h0, 0, 0, 4'b0001, 0, 4'b0000);
    step("b5", 4'b0000, 4'h0, 0, 0, 4'b0001, 1, 4'b0000);
    step("b6", 4'b0000, 4'h0, 1, 0, 4'b0000, 0, 4'b0000);
    step("b7", 4'b0000, 4'h0, 0, 0, 4'b0000, 0, 4'b0000);
    step("c1", 4'b0010, 4'h0, 0, 0, 4'b0010, 0, 4'b0000);
    step("c2", 4'b0000, 4'h0, 0, 0, 4'b0010, 1, 4'b0000);
    step("c3", 4'b0010, 4'h0, 0, 0, 4'b0010, 1, 4'b0010);
    step("c4", 4'b0000, 4'h0, 1, 1, 4'b0000, 0, 4'b0010);
    step("c5", 4'b0000, 4'h0, 0, 0, 4'b0000, 0, 4'b0010);
    step("d1", 4'b0100, 4'h0, 0, 0, 4'b0100, 0, 4'b0010);
    step("d2", 4'b0000, 4'h0, 0, 0, 4'b0100, 1, 4'b0010);
    step("d3", 4'b0100, 4'h0, 1, 2, 4'b0100, 0, 4'b0010);
    step("d4", 4'b0000, 4'h0, 0, 0, 4'b0100, 0, 4'b0010);
    step("d5", 4'b0000, 4'h0, 0, 0, 4'b0100, 1, 4'b0010);
    step("d6", 4'b0000, 4'h0, 1, 2, 4'b0000, 0, 4'b0010);
    step("d7", 4'b0000, 4'h0, 0, 0, 4'b0000, 0, 4'b0010);
    step("e1", 4'b0010, 4'hf, 0, 0, 4'b0000, 0, 4'b0010);
    step("e2", 4'b0000, 4'hf, 0, 0, 4'b0000, 0, 4'b0010);
    mask = 4'h0;
    #1;
    check("e_unmask.pend", pend, 4'b0010);
    step("e3", 4'b0000, 4'h0, 0, 0, 4'b0010, 1, 4'b0010);
    step("e4", 4'b0000, 4'hf, 0, 0, 4'b0000, 0, 4'b0010);
    step("e5", 4'b0000, 4'hf, 1, 1, 4'b0000, 0, 4'b0010);
    step("e6", 4'b0000, 4'h0, 0, 0, 4'b0010, 1, 4'b0010);
    step("e7", 4'b0000, 4'b0010, 1, 1, 4'b0000, 0, 4'b0010);
    step("e8", 4'b0000, 4'h0, 0, 0, 4'b0010, 0, 4'b0010);
    step("e9", 4'b0000, 4'h0, 0, 0, 4'b0010, 1, 4'b0010);
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.pend", pend, 4'h0);
    check("rst_mid.irq", irq, 1'b0);
    check("rst_mid.ovf", ovf, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("hold1", 4'b1111, 4'h0, 0, 0, 4'b0000, 0, 4'b0000);
    step("hold2", 4'b1111, 4'h0, 0, 0, 4'b0000, 0, 4'b0000);
    step("hold3", 4'b0000, 4'h0, 0, 0, 4'b0000, 0, 4'b0000);
    req = 4'b1000;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (pend == 4'h0 && n < 10);
    check("latency", n, LAT);
    check("lat.pend", pend, 4'b1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
